instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction memory: owns the PC, drives
//  the memory's read/addr, registers the returned word with its PC, and hands it
//  to decode over a valid/ready handshake. Handles branch redirect and halt stop.
//  The memory is combinational: addr and read in, word out in the same cycle.
// PARAMETERS
//  ADDR_W     6             PC / imem address width (64 words)
//  DATA_W     32            instruction width
//  RESET_PC   6'd0          PC value after reset
//  HALT_WORD  32'hFFFF_FFFF instruction encoding that stops fetch
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       reset; asynchronous, active-low
//  imem_read  out  1       read strobe to instruction memory
//  imem_addr  out  ADDR_W  word address to instruction memory (= pc)
//  imem_data  in   DATA_W  instruction word returned by memory
//  id_valid   out  1       id_instr/id_pc hold an undelivered instruction
//  id_ready   in   1       decode accepts the instruction this cycle
//  id_instr   out  DATA_W  fetched instruction
//  id_pc      out  ADDR_W  address id_instr was fetched from
//  br_taken   in   1       one-cycle redirect request from execute
//  br_target  in   ADDR_W  redirect address (PC+1+imm, computed in execute)
//  halted     out  1       sticky: halt word was accepted by decode
//  fetch_cnt  out  16      count of instructions accepted by decode
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, id_valid=0, id_instr=0,
//   id_pc=0, halted=0, fetch_cnt=0. imem_read=0 while rst_n=0.
//  States: FETCH, HALT_WAIT, HALTED.
//  Outputs: imem_addr=pc always. imem_read=1 only in FETCH with rst_n=1.
//  Load condition: load = (state==FETCH) && (!id_valid || id_ready).
//  FETCH, load=1, no br_taken: id_instr<=imem_data, id_pc<=pc, id_valid<=1,
//   pc<=pc+1. Latency 1 cycle from the PC being presented to id_instr.
//   If imem_data==HALT_WORD, do not advance pc. Go to HALT_WAIT.
//  FETCH, load=0 (stall): pc, id_* hold. id_instr stays stable while valid && !ready.
//  Accept (id_valid && id_ready) without a reload: id_valid<=0.
//   Every accept does fetch_cnt+=1, including the halt word. fetch_cnt saturates at FFFF.
//  HALT_WAIT: no fetch. On accept of the halt word: halted<=1, id_valid<=0,
//   go to HALTED.
//  HALTED: terminal. Only reset leaves it. br_taken is ignored.
//  br_taken=1 (FETCH or HALT_WAIT), highest priority:
//   - pc<=br_target, id_valid<=0 (the wrong-path instruction is squashed, not
//     counted, even if id_ready=1 that cycle). State<=FETCH.
//   - The target word appears on id_instr 2 edges after br_taken (1 bubble).
//  PC arithmetic is ADDR_W-bit modulo: pc 63 -> 0 wraps silently, with no flag.
//  imem_data is sampled only when imem_read=1. X on the bus at other times must
//   not propagate into id_instr.
//  Reset asserted mid-stall, mid-halt or mid-redirect gives the full reset values
//   immediately. Fetch restarts at RESET_PC on the first edge after release.
// STRUCTURE
//  Shared package risc_pkg: ADDR_W, DATA_W, HALT_WORD, opcode field [31:26],
//   rs [25:21], rt [20:16], imm [15:0] localparams, and the fetch state encoding
//   (FETCH=2'd0, HALT_WAIT=2'd1, HALTED=2'd2).
//  Single module with no sub-modules. The PC register, output register,
//   FSM and counter are small enough to stay inline.
// TESTING (bench instantiates instr_fetch_unit + instruction memory model)
//  1 Reset: hold rst_n=0 for 3 clks, then release with id_ready=1.
//    Expect id_valid=0 during reset, then imem[0..] appears on consecutive cycles,
//    id_pc=0,1,2. Assert rst_n=0 mid-run: all outputs return to reset values at once.
//  2 Backpressure: id_ready=0 for 4 cycles while id_pc=2.
//    Expect id_instr/id_pc stable, pc stays at 3. Release: id_pc=3 next cycle,
//    with none skipped or duplicated.
//  3 Redirect: br_taken=1, br_target=3 while id_pc=1.
//    Expect the id_pc=2 word squashed (fetch_cnt unchanged).
//    Next valid has id_pc=3 with imem[3]; simultaneous id_ready=1 does not count.
//  4 Halt: place 32'hFFFFFFFF at addr 8.
//    Expect imem_read=0 after capture, pc=8, id_instr=FFFFFFFF. halted=1 one edge
//    after accept. fetch_cnt=9 for 0..8 executed linearly. br_taken in HALTED is ignored.
//  5 Wrap: start at br_target=62 with no halt.
//    Expect id_pc sequence 62,63,0,1.
//  6 Halt squash: br_taken while in HALT_WAIT (halt word is wrong-path).
//    Expect halted stays 0 and fetch resumes from br_target.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the small RISC core: datapath widths, the halt
// encoding, instruction field positions and the fetch state encoding.
package risc_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    // Instruction field positions (bit ranges inside a DATA_W word)
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HALT_WAIT = 2'd1,
        HALTED    = 2'd2
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads a combinational instruction memory,
// registers the word with its PC and offers it to decode over valid/ready.
// Branch redirects squash the held word; the halt word stops fetching once
// decode has taken it.
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int                ADDR_W    = risc_pkg::ADDR_W,
    parameter int                DATA_W    = risc_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = risc_pkg::HALT_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_read,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted,
    output logic [15:0]       fetch_cnt
);

    fetch_state_e      state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] instr_q,    instr_d;
    logic [ADDR_W-1:0] id_pc_q,    id_pc_d;
    logic              halted_q,   halted_d;
    logic [15:0]       cnt_q,      cnt_d;

    logic accept;
    logic load;

    assign accept = valid_q && id_ready;
    assign load   = (state_q == FETCH) && (!valid_q || id_ready);

    // Memory is only strobed while actively fetching and out of reset
    assign imem_read = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;
    assign id_valid  = valid_q;
    assign id_instr  = instr_q;
    assign id_pc     = id_pc_q;
    assign halted    = halted_q;
    assign fetch_cnt = cnt_q;

    // Next-state: redirect beats everything; otherwise accept then reload
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        id_pc_d  = id_pc_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;

        if (state_q != HALTED) begin
            if (br_taken) begin
                // Held word is wrong-path: drop it without counting it
                pc_d    = br_target;
                valid_d = 1'b0;
                state_d = FETCH;
            end else begin
                if (accept) begin
                    cnt_d   = sat_inc16(cnt_q);
                    valid_d = 1'b0;
                end
                case (state_q)
                    FETCH: begin
                        if (load) begin
                            instr_d = imem_data;
                            id_pc_d = pc_q;
                            valid_d = 1'b1;
                            if (imem_data == HALT_WORD) begin
                                // Park the PC on the halt word
                                state_d = HALT_WAIT;
                            end else begin
                                pc_d = pc_q + ADDR_W'(1);
                            end
                        end
                    end
                    HALT_WAIT: begin
                        if (accept) begin
                            halted_d = 1'b1;
                            state_d  = HALTED;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            id_pc_q  <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            id_pc_q  <= id_pc_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: combinational instruction memory model,
// a table of single-cycle vectors, and hand-written halt/reset sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [5:0]  id_pc;
    logic        br_taken;
    logic [5:0]  br_target;
    logic        halted;
    logic [15:0] fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Memory contents: tagged words, halt word at address 8
    function automatic logic [31:0] mem_word(input logic [5:0] a);
        if (a == 6'd8) return 32'hFFFF_FFFF;
        return 32'hA500_0000 | {26'd0, a};
    endfunction

    // Junk on the bus when not read, so a sample at the wrong time is visible
    assign imem_data = imem_read ? mem_word(imem_addr) : 32'hBAD0_BAD0;

    instr_fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_read (imem_read),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halted    (halted),
        .fetch_cnt (fetch_cnt)
    );

    typedef struct {
        bit         ready;
        bit         br;
        logic [5:0] tgt;
        bit         e_valid;
        logic [5:0] e_pc;
        logic [5:0] e_addr;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit b, input int t, input bit v,
                       input int p, input int a, input int c);
        vec_t x;
        x.ready = r; x.br = b; x.tgt = 6'(t); x.e_valid = v;
        x.e_pc = 6'(p); x.e_addr = 6'(a); x.e_cnt = c;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " valid"},  32'(id_valid),  32'd0);
        chk({tag, " instr"},  id_instr,       32'd0);
        chk({tag, " id_pc"},  32'(id_pc),     32'd0);
        chk({tag, " halted"}, 32'(halted),    32'd0);
        chk({tag, " cnt"},    32'(fetch_cnt), 32'd0);
        chk({tag, " read"},   32'(imem_read), 32'd0);
        chk({tag, " addr"},   32'(imem_addr), 32'd0);
    endtask

    // Run from reset PC with ready=1 until the halt word at 8 is captured
    task automatic run_to_halt(input string tag);
        id_ready = 1'b1; br_taken = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            step();
            chk($sformatf("%s id_pc[%0d]", tag, i), 32'(id_pc), 32'(i));
            chk($sformatf("%s instr[%0d]", tag, i), id_instr, mem_word(6'(i)));
        end
        chk({tag, " cap read"}, 32'(imem_read), 32'd0);
        chk({tag, " cap addr"}, 32'(imem_addr), 32'd8);
        chk({tag, " cap cnt"},  32'(fetch_cnt), 32'd8);
        chk({tag, " cap valid"}, 32'(id_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;

        // Reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_vals($sformatf("rst%0d", i));
        end
        rst_n = 1'b1;

        // ready br tgt | valid id_pc addr cnt
        add(1, 0, 0,   1, 0, 1, 0);
        add(1, 0, 0,   1, 1, 2, 1);
        add(1, 0, 0,   1, 2, 3, 2);
        add(0, 0, 0,   1, 2, 3, 2);   // backpressure x4
        add(0, 0, 0,   1, 2, 3, 2);
        add(0, 0, 0,   1, 2, 3, 2);
        add(0, 0, 0,   1, 2, 3, 2);
        add(1, 0, 0,   1, 3, 4, 3);
        add(1, 0, 0,   1, 4, 5, 4);
        add(1, 1, 0,   0, 0, 0, 4);   // redirect to 0, ready ignored
        add(1, 0, 0,   1, 0, 1, 4);
        add(1, 0, 0,   1, 1, 2, 5);
        add(1, 1, 3,   0, 0, 3, 5);   // redirect while id_pc=1
        add(1, 0, 0,   1, 3, 4, 5);
        add(1, 0, 0,   1, 4, 5, 6);
        add(1, 1, 62,  0, 0, 62, 6);  // wrap region
        add(1, 0, 0,   1, 62, 63, 6);
        add(1, 0, 0,   1, 63, 0, 7);
        add(1, 0, 0,   1, 0, 1, 8);
        add(1, 0, 0,   1, 1, 2, 9);
        add(0, 0, 0,   1, 1, 2, 9);

        foreach (vecs[i]) begin
            id_ready  = vecs[i].ready;
            br_taken  = vecs[i].br;
            br_target = vecs[i].tgt;
            step();
            chk($sformatf("v%0d valid", i), 32'(id_valid),  32'(vecs[i].e_valid));
            chk($sformatf("v%0d addr", i),  32'(imem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d cnt", i),   32'(fetch_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d read", i),  32'(imem_read), 32'd1);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d id_pc", i), 32'(id_pc), 32'(vecs[i].e_pc));
                chk($sformatf("v%0d instr", i), id_instr, mem_word(vecs[i].e_pc));
            end
            $display("vec %0d: ready=%0d br=%0d tgt=%0d -> valid=%0d id_pc=%0d addr=%0d cnt=%0d",
                     i, vecs[i].ready, vecs[i].br, vecs[i].tgt, id_valid, id_pc, imem_addr, fetch_cnt);
        end
        br_taken = 1'b0;

        // Asynchronous reset mid-run: outputs clear without a clock edge
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        step();
        step();
        rst_n = 1'b1;

        // Linear run into the halt word
        run_to_halt("halt");
        id_ready = 1'b0;
        step();
        chk("halt stall instr",  id_instr,       32'hFFFF_FFFF);
        chk("halt stall halted", 32'(halted),    32'd0);
        chk("halt stall read",   32'(imem_read), 32'd0);
        id_ready = 1'b1;
        step();
        chk("halt acc halted", 32'(halted),    32'd1);
        chk("halt acc cnt",    32'(fetch_cnt), 32'd9);
        chk("halt acc valid",  32'(id_valid),  32'd0);
        br_taken = 1'b1; br_target = 6'd5;
        step();
        br_taken = 1'b0;
        step();
        chk("halted br halted", 32'(halted),    32'd1);
        chk("halted br addr",   32'(imem_addr), 32'd8);
        chk("halted br valid",  32'(id_valid),  32'd0);
        chk("halted br read",   32'(imem_read), 32'd0);
        chk("halted br cnt",    32'(fetch_cnt), 32'd9);
        $display("halt seq: halted=%0d cnt=%0d addr=%0d", halted, fetch_cnt, imem_addr);

        // Halt word squashed by a redirect while waiting for decode
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst2");
        step();
        rst_n = 1'b1;
        run_to_halt("hsq");
        br_taken = 1'b1; br_target = 6'd20;
        step();
        br_taken = 1'b0;
        chk("hsq br valid",  32'(id_valid),  32'd0);
        chk("hsq br cnt",    32'(fetch_cnt), 32'd8);
        chk("hsq br addr",   32'(imem_addr), 32'd20);
        chk("hsq br read",   32'(imem_read), 32'd1);
        step();
        chk("hsq t id_pc",  32'(id_pc),    32'd20);
        chk("hsq t instr",  id_instr,      mem_word(6'd20));
        chk("hsq t valid",  32'(id_valid), 32'd1);
        step();
        chk("hsq t+1 id_pc", 32'(id_pc),     32'd21);
        chk("hsq t+1 cnt",   32'(fetch_cnt), 32'd9);
        chk("hsq halted",    32'(halted),    32'd0);
        $display("halt squash seq: id_pc=%0d cnt=%0d halted=%0d", id_pc, fetch_cnt, halted);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
